// File: rtl/ccu_sched_pkg.sv
// Shared types and helpers for the CCU address scheduler.
package ccu_sched_pkg;

  localparam int unsigned DEFAULT_LINE_OFFSET = 6;

  typedef logic [15:0] sched_cnt_t;

  function automatic logic [63:0] line_of(input logic [63:0] addr, input int unsigned offset);
    return addr >> offset;
  endfunction

endpackage

// File: rtl/ccu_rr_pick.sv
// Round-robin picker: registered pointer and first-eligible search from it.
module ccu_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         eligible_i,
  input  logic                       advance_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       any_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d, idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    ptr_d       = ptr_q;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!any_o && eligible_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        ptr_d        = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ccu_addr_scheduler.sv
// Round-robin line-conflict-aware request scheduler with in-order in-flight table.
// Optional CCU_SCHED_STATS_EN adds a saturating conflict-cycle counter port.
module ccu_addr_scheduler
  import ccu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_OFFSET  = DEFAULT_LINE_OFFSET,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [ADDR_WIDTH-1:0]             out_addr_o,
  output logic [$clog2(NUM_REQ)-1:0]        out_id_o,
  input  logic                              done_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              busy_o
`ifdef CCU_SCHED_STATS_EN
  ,output sched_cnt_t                       conflict_cnt_o
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W  = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned LINE_W = ADDR_WIDTH - LINE_OFFSET;

  logic [LINE_W-1:0]       tbl_line_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] tbl_vld_q;
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [CNT_W-1:0]        inflight_q;

  logic [LINE_W-1:0]  req_line [NUM_REQ];
  logic [LINE_W-1:0]  out_line;
  logic [NUM_REQ-1:0] tbl_hit, out_hit, eligible, pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any, capacity_ok, grant_allowed, fire, push, pop;

  assign out_line = LINE_W'(line_of(64'(out_addr_o), LINE_OFFSET));

  // Parallel lookup of every requester line against all valid entries and the held output.
  always_comb begin
    tbl_hit  = '0;
    out_hit  = '0;
    eligible = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_line[r] = LINE_W'(line_of(64'(req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]), LINE_OFFSET));
      for (int unsigned e = 0; e < MAX_INFLIGHT; e++) begin
        if (tbl_vld_q[e] && (tbl_line_q[e] == req_line[r])) tbl_hit[r] = 1'b1;
      end
      out_hit[r]  = out_valid_o && (out_line == req_line[r]);
      eligible[r] = req_valid_i[r] && !tbl_hit[r] && !out_hit[r];
    end
  end

  // Held output slot is counted so an accepted handshake always has a table entry.
  assign capacity_ok   = ({1'b0, inflight_q} + {{CNT_W{1'b0}}, out_valid_o})
                         < (CNT_W+1)'(MAX_INFLIGHT);
  assign grant_allowed = rst_ni && capacity_ok && (!out_valid_o || out_ready_i);
  assign fire          = grant_allowed && pick_any;
  assign req_ready_o   = grant_allowed ? pick_grant : '0;

  ccu_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .eligible_i  (eligible),
    .advance_i   (fire),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      out_id_o    <= '0;
    end else if (fire) begin
      out_valid_o <= 1'b1;
      out_addr_o  <= req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      out_id_o    <= pick_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign push = out_valid_o && out_ready_i;
  assign pop  = done_i && (inflight_q != '0);

  always_ff @(posedge clk_i) begin
    if (push) tbl_line_q[tail_q] <= out_line;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_vld_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= '0;
    end else begin
      if (pop) begin
        tbl_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (push) begin
        tbl_vld_q[tail_q] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = out_valid_o || (inflight_q != '0);

`ifdef CCU_SCHED_STATS_EN
  logic conflict_seen;
  assign conflict_seen = |(req_valid_i & (tbl_hit | out_hit));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_o <= '0;
    end else if (conflict_seen && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ccu_addr_scheduler.sv
// Directed self-checking bench for ccu_addr_scheduler (NUM_REQ=4, MAX_INFLIGHT=4).
module tb_ccu_addr_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_addr;
  logic [1:0]   out_id;
  logic         done;
  logic [2:0]   inflight;
  logic         busy;
`ifdef CCU_SCHED_STATS_EN
  logic [15:0]  conflict_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ccu_addr_scheduler #(
    .NUM_REQ      (4),
    .ADDR_WIDTH   (32),
    .LINE_OFFSET  (6),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .out_id_o    (out_id),
    .done_i      (done),
    .inflight_o  (inflight),
    .busy_o      (busy)
`ifdef CCU_SCHED_STATS_EN
    ,.conflict_cnt_o (conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int r, input logic [31:0] a);
    req_addr[r*32 +: 32] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'b1111; out_ready = 1'b1; done = 1'b0; req_addr = '0;
    set_addr(0, 32'h000); set_addr(1, 32'h040); set_addr(2, 32'h080); set_addr(3, 32'h0C0);
    #2;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_oaddr", out_addr, 32'h0);
    chk("rst_infl", inflight, 3'd0);
    chk("rst_busy", busy, 1'b0);
    step(); step();
    rst_n = 1'b1; #1;

    // Round robin across four distinct lines
    chk("rr_g0", req_ready, 4'b0001);
    step(); chk("rr_id0", out_id, 2'd0); chk("rr_g1", req_ready, 4'b0010);
    step(); chk("rr_id1", out_id, 2'd1); chk("rr_g2", req_ready, 4'b0100);
    step(); chk("rr_id2", out_id, 2'd2); chk("rr_g3", req_ready, 4'b1000);
    chk("rr_infl2", inflight, 3'd2);
    step(); chk("rr_id3", out_id, 2'd3); chk("rr_full_g", req_ready, 4'b0000);
    chk("rr_infl3", inflight, 3'd3);
    step(); chk("rr_ovalid0", out_valid, 1'b0); chk("rr_infl4", inflight, 3'd4);
    chk("rr_busy", busy, 1'b1);
    set_addr(0, 32'h100); #1;
    chk("cap_block", req_ready, 4'b0000);
    req_valid = 4'b0000; done = 1'b1;
    step(); chk("drain1", inflight, 3'd3);
    step(); step(); step(); chk("drain4", inflight, 3'd0);
    step(); chk("done_empty", inflight, 3'd0);
    done = 1'b0; chk("idle_busy", busy, 1'b0);

    // Same-line conflict held until the cycle after done
    req_valid = 4'b0001; set_addr(0, 32'h1000); #1;
    chk("cf_g0", req_ready, 4'b0001);
    step(); chk("cf_oaddr0", out_addr, 32'h1000); chk("cf_oid0", out_id, 2'd0);
    req_valid = 4'b0010; set_addr(1, 32'h1020); #1;
    chk("cf_vs_out", req_ready, 4'b0000);
    step(); chk("cf_infl1", inflight, 3'd1); chk("cf_vs_tbl", req_ready, 4'b0000);
    step(); chk("cf_vs_tbl2", req_ready, 4'b0000);
    done = 1'b1; #1;
    chk("cf_nobypass", req_ready, 4'b0000);
    step(); done = 1'b0; #1;
    chk("cf_free", req_ready, 4'b0010);
    step(); chk("cf_oid1", out_id, 2'd1); chk("cf_oaddr1", out_addr, 32'h1020);
    chk("cf_infl0", inflight, 3'd0);

    // Backpressure: hold for five cycles with another requester waiting
    out_ready = 1'b0; req_valid = 4'b0100; set_addr(2, 32'h2000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_oaddr", out_addr, 32'h1020);
      chk("bp_oid", out_id, 2'd1);
      chk("bp_ovalid", out_valid, 1'b1);
      chk("bp_ready", req_ready, 4'b0000);
    end
    req_valid = 4'b0000; out_ready = 1'b1;
    step(); chk("bp_push", inflight, 3'd1); chk("bp_ovalid0", out_valid, 1'b0);

    // Simultaneous push and retire at inflight=2
    req_valid = 4'b0100; #1;
    chk("sp_g2", req_ready, 4'b0100);
    step(); req_valid = 4'b0000; chk("sp_oaddr2", out_addr, 32'h2000);
    step(); chk("sp_infl2", inflight, 3'd2);
    req_valid = 4'b1000; set_addr(3, 32'h3000); #1;
    chk("sp_g3", req_ready, 4'b1000);
    step(); req_valid = 4'b0000; done = 1'b1;
    chk("sp_pre", inflight, 3'd2);
    step(); done = 1'b0;
    chk("sp_same", inflight, 3'd2); chk("sp_ovalid0", out_valid, 1'b0);
    req_valid = 4'b0011; set_addr(0, 32'h2000); set_addr(1, 32'h1020); #1;
    chk("sp_head_ret", req_ready, 4'b0010);
    req_valid = 4'b0000;

    // Fill to wrap the tail, then retire and pick with pointer wrap
    req_valid = 4'b0001; set_addr(0, 32'h4000); #1;
    chk("wr_g0", req_ready, 4'b0001);
    step(); req_valid = 4'b0010; set_addr(1, 32'h5000); #1;
    chk("wr_g1", req_ready, 4'b0010);
    step(); req_valid = 4'b0000; chk("wr_oaddr", out_addr, 32'h5000);
    step(); chk("wr_full", inflight, 3'd4);
    done = 1'b1;
    step(); done = 1'b0; chk("wr_infl3", inflight, 3'd3);
    req_valid = 4'b1111;
    set_addr(0, 32'h2010); set_addr(1, 32'h3000); set_addr(2, 32'h4000); set_addr(3, 32'h5008); #1;
    chk("wr_pick", req_ready, 4'b0001);
    step(); req_valid = 4'b0000;
    chk("wr_oid", out_id, 2'd0); chk("wr_oaddr0", out_addr, 32'h2010);

`ifdef CCU_SCHED_STATS_EN
    rst_n = 1'b0; #1;
    chk("st_rst", conflict_cnt, 16'h0);
    rst_n = 1'b1;
    req_valid = 4'b0001; set_addr(0, 32'h6000);
    step(); req_valid = 4'b0000;
    step();
    req_valid = 4'b0010; set_addr(1, 32'h6000);
    repeat (7) step();
    req_valid = 4'b0000; #1;
    chk("st_cnt7", conflict_cnt, 16'd7);
    req_valid = 4'b0010;
    repeat (65535 - 7) step();
    chk("st_max", conflict_cnt, 16'hFFFF);
    step();
    chk("st_sat", conflict_cnt, 16'hFFFF);
    req_valid = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
